// File: rtl/ff_excitation_gen.sv
// Flip-flop excitation generator: converts a stream of desired next-Q bits into D/T/SR/JK inputs.
// Define FF_SELF_CHECK_EN to add a behavioural check of every emitted excitation (drives err).
module ff_excitation_gen #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       exc,
    output logic [1:0]       mode_act,
    output logic             q_model,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic             busy,
    output logic             err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [1:0] MODE_D  = 2'b00;
    localparam logic [1:0] MODE_T  = 2'b01;
    localparam logic [1:0] MODE_SR = 2'b10;
    localparam logic [1:0] MODE_JK = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e           state_q, state_d;
    logic [1:0]       mode_act_q, mode_act_d;
    logic [AW:0]      count_q, count_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             fifo_q [DEPTH];
    logic             out_valid_q, out_valid_d;
    logic [1:0]       exc_q, exc_d;
    logic             tgt_q, tgt_d;
    logic             shadow_q, shadow_d;
    logic             q_model_q, q_model_d;
    logic [CNT_W-1:0] toggle_cnt_q, toggle_cnt_d;
    logic             push, pop, out_fire, head;

    function automatic logic [1:0] excite(input logic [1:0] m, input logic q, input logic qn);
        case (m)
            MODE_D:           excite = {1'b0, qn};
            MODE_T:           excite = {1'b0, q ^ qn};
            MODE_SR, MODE_JK: excite = {~q & qn, q & ~qn};
            default:          excite = 2'b00;
        endcase
    endfunction

    assign in_ready = (count_q != FULL_CNT) && (state_q != DRAIN);
    assign head     = fifo_q[rd_ptr_q];

    // NOTE: every _d signal is given its hold value first, so no path can infer a latch.
    always_comb begin
        push         = in_valid && in_ready;
        out_fire     = out_valid_q && out_ready;
        pop          = (state_q != IDLE) && (count_q != '0) && (!out_valid_q || out_fire);

        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        out_valid_d  = out_valid_q;
        exc_d        = exc_q;
        tgt_d        = tgt_q;
        shadow_d     = shadow_q;
        q_model_d    = q_model_q;
        toggle_cnt_d = toggle_cnt_q;
        state_d      = state_q;
        mode_act_d   = mode_act_q;

        if (push)         wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)          rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop) count_d  = count_q + 1'b1;
        if (pop && !push) count_d  = count_q - 1'b1;

        // Shadow Q already includes every loaded entry, so exc is right even while q_model lags.
        if (pop) begin
            out_valid_d = 1'b1;
            exc_d       = excite(mode_act_q, shadow_q, head);
            tgt_d       = head;
            shadow_d    = head;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end

        if (out_fire) begin
            q_model_d = tgt_q;
            if ((tgt_q != q_model_q) && (toggle_cnt_q != {CNT_W{1'b1}}))
                toggle_cnt_d = toggle_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (mode != mode_act_q) mode_act_d = mode;
                if (push)               state_d    = RUN;
            end
            RUN: begin
                if (mode != mode_act_q)                   state_d = DRAIN;
                else if ((count_d == '0) && !out_valid_d) state_d = IDLE;
            end
            DRAIN: begin
                if ((count_q == '0) && !out_valid_q) begin
                    mode_act_d = mode;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mode_act_q   <= mode;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            out_valid_q  <= 1'b0;
            exc_q        <= 2'b00;
            tgt_q        <= 1'b0;
            shadow_q     <= 1'b0;
            q_model_q    <= 1'b0;
            toggle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            mode_act_q   <= mode_act_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            out_valid_q  <= out_valid_d;
            exc_q        <= exc_d;
            tgt_q        <= tgt_d;
            shadow_q     <= shadow_d;
            q_model_q    <= q_model_d;
            toggle_cnt_q <= toggle_cnt_d;
        end
    end

    // NOTE: FIFO storage is not reset; count and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= in_q;
    end

`ifdef FF_SELF_CHECK_EN
    logic err_q, err_d, chk_next, chk_bad;

    always_comb begin
        chk_next = q_model_q;
        chk_bad  = 1'b0;
        case (mode_act_q)
            MODE_D: chk_next = exc_q[0];
            MODE_T: chk_next = q_model_q ^ exc_q[0];
            MODE_SR: begin
                chk_bad = exc_q[1] & exc_q[0];
                if (exc_q[1])      chk_next = 1'b1;
                else if (exc_q[0]) chk_next = 1'b0;
            end
            default: begin
                if (exc_q == 2'b11) chk_next = ~q_model_q;
                else if (exc_q[1])  chk_next = 1'b1;
                else if (exc_q[0])  chk_next = 1'b0;
            end
        endcase
        err_d = err_q | (out_fire & (chk_bad | (chk_next != tgt_q)));
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign out_valid  = out_valid_q;
    assign exc        = exc_q;
    assign mode_act   = mode_act_q;
    assign q_model    = q_model_q;
    assign toggle_cnt = toggle_cnt_q;
    assign busy       = (count_q != '0) || out_valid_q;

endmodule

// File: tb/tb_ff_excitation_gen.sv
// Self-checking bench for ff_excitation_gen: directed scenarios plus a random run,
// scored against a queue-based model of the flip-flop excitation tables.
module tb_ff_excitation_gen;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       mode;
    logic             in_valid;
    logic             in_ready;
    logic             in_q;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       exc;
    logic [1:0]       mode_act;
    logic             q_model;
    logic [CNT_W-1:0] toggle_cnt;
    logic             busy;
    logic             err;

    ff_excitation_gen #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_q(in_q),
        .out_valid(out_valid), .out_ready(out_ready), .exc(exc),
        .mode_act(mode_act), .q_model(q_model), .toggle_cnt(toggle_cnt),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] exc;
        logic       tgt;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic       mq, tail, stall_prev, last_push;
    int         mtog, n_push, n_fire;
    logic [1:0] stall_exc;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Excitation tables of the four flip-flop types, don't-cares resolved to 0.
    function automatic logic [1:0] want_exc(logic [1:0] m, logic q, logic qn);
        if (m == 2'b00) return {1'b0, qn};
        if (m == 2'b01) return {1'b0, q != qn};
        case ({q, qn})
            2'b01:   return 2'b10;
            2'b10:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // One clock: score handshakes at the falling edge, then step past the rising edge.
    task automatic cycle();
        logic push, fire;
        exp_t e;
        @(negedge clk);
        push = in_valid && in_ready;
        fire = out_valid && out_ready;
        if (stall_prev) begin
            check("hold_valid", out_valid, 1);
            check("hold_exc", exc, stall_exc);
        end
        stall_prev = out_valid && !out_ready;
        stall_exc  = exc;
        if (fire) begin
            n_fire++;
            if (exp_q.size() == 0) begin
                check("stale_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("exc", exc, e.exc);
                if (e.tgt != mq && mtog < CNT_MAX) mtog++;
                mq = e.tgt;
            end
        end
        if (push) begin
            exp_q.push_back('{exc: want_exc(mode, tail, in_q), tgt: in_q});
            tail = in_q;
            n_push++;
        end
        last_push = push;
        @(posedge clk);
        #1;
        if (fire) begin
            check("q_model", q_model, mq);
            check("toggle_cnt", toggle_cnt, mtog);
        end
    endtask

    task automatic do_reset(logic [1:0] m);
        mode = m; rst = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        mq = 1'b0; mtog = 0; tail = 1'b0; stall_prev = 1'b0;
    endtask

    task automatic send(logic v);
        int n = 0;
        in_valid = 1'b1;
        in_q = v;
        do begin
            cycle();
            n++;
        end while (!last_push && n < 32);
        check("send_accept", last_push, 1);
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || busy) && n < 64) begin
            cycle();
            n++;
        end
        check("drain_done", {exp_q.size() != 0, busy}, 0);
    endtask

    initial begin
        #500000;
        $fatal(1, "FAIL watchdog timeout");
    end

    initial begin
        int fires0, pushes0, k;
        rst = 1'b1; mode = 2'b00; in_valid = 1'b0; in_q = 1'b0; out_ready = 1'b0;
        n_push = 0; n_fire = 0; last_push = 1'b0;

        // Reset state.
        do_reset(2'b00);
        check("rst_out_valid", out_valid, 0);
        check("rst_exc", exc, 0);
        check("rst_q_model", q_model, 0);
        check("rst_toggle", toggle_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_mode_act", mode_act, 2'b00);
        check("rst_in_ready", in_ready, 1);

        // D mode, stream 1,0,0,1 with first-output latency.
        out_ready = 1'b1;
        send(1'b1);
        check("lat_edge_n", out_valid, 0);
        send(1'b0);
        check("lat_edge_n1", out_valid, 1);
        send(1'b0);
        send(1'b1);
        drain();
        check("d_q_model", q_model, 1);
        check("d_toggle", toggle_cnt, 3);

        // JK mode from reset, stream 1,1,0,0.
        do_reset(2'b11);
        check("jk_mode_act", mode_act, 2'b11);
        out_ready = 1'b1;
        send(1'b1); send(1'b1); send(1'b0); send(1'b0);
        drain();
        check("jk_toggle", toggle_cnt, 2);
        check("jk_err", err, 0);

        // T mode with a stalled consumer: DEPTH in FIFO plus one held in the output stage.
        do_reset(2'b01);
        out_ready = 1'b0;
        pushes0 = n_push;
        send(1'b1); send(1'b1); send(1'b0); send(1'b1); send(1'b0);
        in_q = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        check("t_accepted", n_push - pushes0, 5);
        check("t_in_ready_full", in_ready, 0);
        check("t_busy", busy, 1);
        fires0 = n_fire;
        drain();
        check("t_emitted", n_fire - fires0, 5);

        // SR mode, queued entries, then switch to JK mid-stream.
        do_reset(2'b10);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(1'($urandom));
        in_valid = 1'b0;
        mode = 2'b11;
        cycle();
        check("drain_in_ready", in_ready, 0);
        in_valid = 1'b1; in_q = 1'b1;
        cycle();
        check("drain_no_accept", last_push, 0);
        in_valid = 1'b0;
        check("drain_old_mode", mode_act, 2'b10);
        drain();
        k = 0;
        while (!in_ready && k < 8) begin
            cycle();
            k++;
        end
        check("drain_exit_ready", in_ready, 1);
        check("drain_new_mode", mode_act, 2'b11);
        for (int i = 0; i < 4; i++) send(1'($urandom));
        drain();

        // Random traffic with back-pressure and occasional mode changes.
        do_reset(2'($urandom));
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(15) == 0) begin
                in_valid = 1'b0;
                mode = 2'($urandom);
            end else begin
                in_valid = ($urandom_range(3) != 0);
                in_q = 1'($urandom);
            end
            out_ready = ($urandom_range(2) != 0);
            cycle();
        end
        drain();
        check("rand_err", err, 0);

        // Toggle counter saturation with an alternating stream.
        do_reset(2'b00);
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) send(~i[0]);
        drain();
        check("sat_toggle", toggle_cnt, CNT_MAX);

        // Reset while the FIFO holds 3 entries and the stage holds one.
        do_reset(2'b00);
        out_ready = 1'b1;
        send(1'b1);
        drain();
        check("pre_rst_q_model", q_model, 1);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(1'(i));
        check("pre_rst_busy", busy, 1);
        do_reset(2'b00);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_q_model", q_model, 0);
        check("mid_rst_toggle", toggle_cnt, 0);
        out_ready = 1'b1;
        fires0 = n_fire;
        for (int i = 0; i < 8; i++) cycle();
        check("no_stale_out", n_fire - fires0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
